fifo_rd_framer: RTL and testbench
=================================

# fifo_rd_framer

Read-side framing stage on the receive/transmit clock domain of the MAC datapath, directly downstream of the async FIFO read port. It pulls bytes from the FIFO with `fifo_r_en`, absorbs the FIFO's one-cycle read latency in a 2-entry output buffer, and emits fixed-length frames on a valid/ready byte stream with `m_last` on the final byte. After each frame it enforces a programmable inter-frame gap.

## Interface
- `WIDTH`, 8: data width, matches FIFO `WIDTH`.
- `LEN_W`, 16: width of `frame_len`.
- `IFG`, 12: inter-frame gap in `rclk` cycles; 0 allowed.

- `rclk`  in  1: clock; FIFO read clock.
- `srst`  in  1: reset; synchronous, active-high.
- `start`  in  1: one-cycle request to send a frame; sampled only in IDLE.
- `frame_len`  in  LEN_W: byte count, latched with `start`.
- `busy`  out  1: high in every state except IDLE.
- `done`  out  1: one-cycle pulse on return to IDLE.
- `fifo_empty`  in  1: FIFO empty flag.
- `fifo_r_en`  out  1: FIFO read strobe.
- `fifo_data`  in  WIDTH: FIFO read data, valid the cycle after `fifo_r_en`.
- `m_data`  out  WIDTH: stream data.
- `m_valid`  out  1: stream valid.
- `m_last`  out  1: marks final byte of frame; qualified by `m_valid`.
- `m_ready`  in  1: stream ready from consumer.
- `frame_cnt`  out  16: completed frames; present only with `RD_STATS_EN`.

## Operation
- States: IDLE, STREAM, GAP.
- IDLE -> STREAM when `start`=1 and `frame_len`!=0; latch `frame_len` into `req_left` and `out_left`. `start` with `frame_len`=0 is ignored (no `done`). `start` outside IDLE is ignored.
- STREAM: `fifo_r_en`=1 when `fifo_empty`=0, `req_left`!=0, and (buffer occupancy + in-flight reads − pop this cycle) < 2, where pop = `m_valid & m_ready`. Each read decrements `req_left`; the returned byte is written into the buffer the next cycle, tagged `last` when it was the read that took `req_left` from 1 to 0.
- `fifo_r_en` is never asserted when `fifo_empty`=1, nor outside STREAM.
- Buffer: 2-entry FIFO order; `m_valid` = occupancy != 0; `m_data`/`m_last` from head entry. Head holds stable while `m_valid` & !`m_ready`.
- STREAM -> GAP on handshake of the `last` byte. GAP counts `IFG` cycles, then -> IDLE with `done`=1 for one cycle. `IFG`=0: STREAM -> IDLE directly, `done` on the cycle after the last handshake.
- FIFO empty mid-frame: stall reads, no timeout, no error.
- Counters: `req_left` and `out_left` are LEN_W bits, no wrap possible (decrement only when nonzero).
- `srst`: state IDLE, occupancy 0, in-flight cleared, counters 0; buffered bytes discarded; FIFO pointers not rewound (bytes already read are lost).

## Timing
- Reset values: `busy`=0, `done`=0, `fifo_r_en`=0, `m_valid`=0, `m_last`=0, `m_data`=0, `frame_cnt`=0.
- `start` in cycle 0 with FIFO non-empty: `fifo_r_en` cycle 1, `m_valid` cycle 3.
- Throughput: 1 byte/cycle with `m_ready` held high and FIFO non-empty; no bubbles.
- `m_ready` low: at most 2 bytes buffered; reads resume the cycle a pop frees space.
- All outputs registered except `fifo_r_en` (combinational from state, counters, `fifo_empty`, `m_ready`).

## Configuration
- `RD_STATS_EN` defined: `frame_cnt` port exists; increments on each `done`, saturates at 0xFFFF, cleared by `srst`.
- Undefined: port and counter absent; all other behaviour identical.

## Test plan
- Reset mid-frame: `frame_len`=10, `srst` after 4 handshakes -> next cycle `m_valid`=0, `busy`=0, no `done`; fresh `start` works.
- Streaming: FIFO preloaded 0x01..0x05, `frame_len`=5, `m_ready`=1 -> bytes 0x01..0x05 on cycles 3..7, `m_last` only with 0x05, `done` 12 cycles after last handshake.
- Backpressure: `frame_len`=8, `m_ready` toggled 1/0 each cycle -> no byte lost/duplicated, `fifo_r_en` total = 8, never >2 bytes pending.
- Empty stall: FIFO holds 3 bytes, `frame_len`=6, write 3 more after 20 cycles -> `fifo_r_en`=0 while empty, frame completes with 6 bytes, `m_last` on 6th.
- Boundaries: `frame_len`=0 -> stays IDLE, no `done`; `frame_len`=1 -> single byte with `m_last`=1; `start` during GAP ignored.
- `RD_STATS_EN`: 3 frames of length 2 -> `frame_cnt`=3; force to 0xFFFF and complete one frame -> stays 0xFFFF.

Source files
------------

// File: rtl/fifo_rd_framer.sv
// Read-side framer: pulls bytes from the async FIFO read port and emits fixed-length
// valid/ready frames followed by an inter-frame gap. Define RD_STATS_EN for frame_cnt.
module fifo_rd_framer #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned LEN_W = 16,
    parameter int unsigned IFG   = 12
) (
    input  logic             rclk,
    input  logic             srst,
    input  logic             start,
    input  logic [LEN_W-1:0] frame_len,
    output logic             busy,
    output logic             done,
    input  logic             fifo_empty,
    output logic             fifo_r_en,
    input  logic [WIDTH-1:0] fifo_data,
    output logic [WIDTH-1:0] m_data,
    output logic             m_valid,
    output logic             m_last,
    input  logic             m_ready
`ifdef RD_STATS_EN
    ,
    output logic [15:0]      frame_cnt
`endif
);

    // Gap is measured from the last handshake cycle, so GAP itself lasts IFG-1 cycles.
    localparam int unsigned GAP_W    = (IFG > 2) ? $clog2(IFG) : 1;
    localparam int unsigned GAP_INIT = (IFG > 1) ? IFG - 2 : 0;
    localparam bit          SKIP_GAP = (IFG <= 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        GAP    = 2'd2
    } state_t;

    state_t             state;
    state_t             state_n;
    logic               done_n;
    logic [LEN_W-1:0]   req_left;
    logic [LEN_W-1:0]   out_left;
    logic [GAP_W-1:0]   gap_cnt;
    logic               inflight;
    logic               inflight_last;
    logic [1:0]         occ;
    logic [1:0]         occ_n;
    logic [WIDTH-1:0]   tail_data;
    logic               tail_last;
    logic [WIDTH-1:0]   head_data_n;
    logic               head_last_n;
    logic [WIDTH-1:0]   tail_data_n;
    logic               tail_last_n;
    logic               pop;

    assign pop = m_valid & m_ready;

    // A read may issue only if its byte is guaranteed a buffer slot on arrival.
    assign fifo_r_en = (state == STREAM) && !fifo_empty && (req_left != '0) &&
                       ((3'(occ) + 3'(inflight) - 3'(pop)) < 3'd2);

    always_comb begin
        state_n = state;
        done_n  = 1'b0;
        unique case (state)
            IDLE: begin
                if (start && (frame_len != '0)) begin
                    state_n = STREAM;
                end
            end
            STREAM: begin
                if (pop && (out_left == LEN_W'(1))) begin
                    if (SKIP_GAP) begin
                        state_n = IDLE;
                        done_n  = 1'b1;
                    end else begin
                        state_n = GAP;
                    end
                end
            end
            GAP: begin
                if (gap_cnt == '0) begin
                    state_n = IDLE;
                    done_n  = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Two-entry output buffer: head drives the stream, tail catches the next byte.
    always_comb begin
        occ_n       = occ;
        head_data_n = m_data;
        head_last_n = m_last;
        tail_data_n = tail_data;
        tail_last_n = tail_last;
        if (pop) begin
            head_data_n = tail_data;
            head_last_n = tail_last;
            occ_n       = occ - 2'd1;
        end
        if (inflight) begin
            if (occ_n == 2'd0) begin
                head_data_n = fifo_data;
                head_last_n = inflight_last;
            end else begin
                tail_data_n = fifo_data;
                tail_last_n = inflight_last;
            end
            occ_n = occ_n + 2'd1;
        end
        if (occ_n == 2'd0) begin
            head_last_n = 1'b0;
        end
    end

    always_ff @(posedge rclk) begin
        if (srst) begin
            state         <= IDLE;
            busy          <= 1'b0;
            done          <= 1'b0;
            req_left      <= '0;
            out_left      <= '0;
            gap_cnt       <= '0;
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
            occ           <= 2'd0;
            m_valid       <= 1'b0;
            m_data        <= '0;
            m_last        <= 1'b0;
            tail_data     <= '0;
            tail_last     <= 1'b0;
        end else begin
            state <= state_n;
            busy  <= (state_n != IDLE);
            done  <= done_n;

            if (state == IDLE) begin
                if (state_n == STREAM) begin
                    req_left <= frame_len;
                    out_left <= frame_len;
                end
            end else begin
                if (fifo_r_en) begin
                    req_left <= req_left - LEN_W'(1);
                end
                if (pop && (out_left != '0)) begin
                    out_left <= out_left - LEN_W'(1);
                end
            end

            if (state == GAP) begin
                if (gap_cnt != '0) begin
                    gap_cnt <= gap_cnt - GAP_W'(1);
                end
            end else begin
                gap_cnt <= GAP_W'(GAP_INIT);
            end

            inflight      <= fifo_r_en;
            inflight_last <= fifo_r_en && (req_left == LEN_W'(1));
            occ           <= occ_n;
            m_valid       <= (occ_n != 2'd0);
            m_data        <= head_data_n;
            m_last        <= head_last_n;
            tail_data     <= tail_data_n;
            tail_last     <= tail_last_n;
        end
    end

`ifdef RD_STATS_EN
    // Saturating count of completed frames.
    always_ff @(posedge rclk) begin
        if (srst) begin
            frame_cnt <= 16'd0;
        end else if (done_n && (frame_cnt != 16'hFFFF)) begin
            frame_cnt <= frame_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fifo_rd_framer.sv
// Self-checking bench for fifo_rd_framer: queue-based FIFO model, byte scoreboard,
// and cycle-accurate expectations for busy/done/latency.
module tb_fifo_rd_framer;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned LEN_W = 16;
    localparam int unsigned IFG   = 12;
    localparam int          GAP_CYC = (IFG > 1) ? int'(IFG) : 1;

    logic             rclk = 1'b0;
    logic             srst;
    logic             start;
    logic [LEN_W-1:0] frame_len;
    logic             busy;
    logic             done;
    logic             fifo_empty;
    logic             fifo_r_en;
    logic [WIDTH-1:0] fifo_data;
    logic [WIDTH-1:0] m_data;
    logic             m_valid;
    logic             m_last;
    logic             m_ready;
`ifdef RD_STATS_EN
    logic [15:0]      frame_cnt;
`endif

    fifo_rd_framer #(.WIDTH(WIDTH), .LEN_W(LEN_W), .IFG(IFG)) dut (
        .rclk       (rclk),
        .srst       (srst),
        .start      (start),
        .frame_len  (frame_len),
        .busy       (busy),
        .done       (done),
        .fifo_empty (fifo_empty),
        .fifo_r_en  (fifo_r_en),
        .fifo_data  (fifo_data),
        .m_data     (m_data),
        .m_valid    (m_valid),
        .m_last     (m_last),
        .m_ready    (m_ready)
`ifdef RD_STATS_EN
        ,
        .frame_cnt  (frame_cnt)
`endif
    );

    always #5 rclk = ~rclk;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;

    logic [7:0] q[$];      // bytes physically in the FIFO
    logic [7:0] src[$];    // FIFO bytes not yet claimed by an accepted frame
    logic [8:0] exp_q[$];  // {last, data} expected on the stream
    int  need = 0;         // bytes an accepted frame still waits for from future writes

    bit  frame_open   = 1'b0;
    bit  done_pending = 1'b0;
    int  done_due     = 0;
    int  last_done_cyc = -1;
    int  rd_cnt = 0;
    int  hs_cnt = 0;
    int  rd_cyc[$];
    int  hs_cyc[$];
    bit  mon_en = 1'b0;
    int  ready_mode = 0;   // 0: always ready, 1: random, 2: toggle

    always @(posedge rclk) cyc++;

    always @(posedge rclk) begin
        #1;
        case (ready_mode)
            0:       m_ready = 1'b1;
            1:       m_ready = 1'($urandom_range(0, 3) != 0);
            default: m_ready = !m_ready;
        endcase
    end

    // FIFO with one-cycle read latency.
    always @(posedge rclk) begin : fifo_model
        logic [7:0] b;
        if (fifo_r_en) begin
            if (q.size() != 0) begin
                b = q.pop_front();
                fifo_data <= b;
            end
            fifo_empty <= (q.size() == 0);
        end
    end

    always @(negedge rclk) begin : monitor
        logic       exp_done;
        logic [8:0] e;
        if (mon_en && !srst) begin
            n_vec++;
            if (fifo_r_en && (fifo_empty || !frame_open)) begin
                n_err++;
                $display("FAIL rd_legal cyc=%0d r_en=%0b empty=%0b open=%0b", cyc, fifo_r_en, fifo_empty, frame_open);
            end
            if (fifo_r_en) begin
                rd_cnt++;
                rd_cyc.push_back(cyc);
            end
            exp_done = done_pending && (cyc == done_due);
            n_vec++;
            if (done !== exp_done) begin
                n_err++;
                $display("FAIL done cyc=%0d got=%0b exp=%0b", cyc, done, exp_done);
            end
            if (done === 1'b1) last_done_cyc = cyc;
            if (exp_done) begin
                done_pending = 1'b0;
                frame_open   = 1'b0;
            end
            n_vec++;
            if (busy !== frame_open) begin
                n_err++;
                $display("FAIL busy cyc=%0d got=%0b exp=%0b", cyc, busy, frame_open);
            end
            if (m_valid && m_ready) begin
                hs_cnt++;
                hs_cyc.push_back(cyc);
                n_vec++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL extra_byte cyc=%0d got=%02h last=%0b exp=none", cyc, m_data, m_last);
                end else begin
                    e = exp_q.pop_front();
                    if ({m_last, m_data} !== e) begin
                        n_err++;
                        $display("FAIL byte cyc=%0d got=%0b/%02h exp=%0b/%02h", cyc, m_last, m_data, e[8], e[7:0]);
                    end
                    if (e[8]) begin
                        done_pending = 1'b1;
                        done_due     = cyc + GAP_CYC;
                    end
                end
            end
            n_vec++;
            if (rd_cnt - hs_cnt > 2) begin
                n_err++;
                $display("FAIL pending cyc=%0d got=%0d exp<=2", cyc, rd_cnt - hs_cnt);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog cyc=%0d got=running exp=finished", cyc);
        $fatal(1);
    end

    task automatic step();
        @(posedge rclk);
        #1;
    endtask

    task automatic push_byte(input logic [7:0] b);
        q.push_back(b);
        fifo_empty = 1'b0;
        if (need > 0) begin
            need--;
            exp_q.push_back({1'(need == 0), b});
        end else begin
            src.push_back(b);
        end
    endtask

    task automatic accept_frame(input int len);
        logic [7:0] b;
        for (int i = 0; i < len; i++) begin
            if (src.size() != 0) begin
                b = src.pop_front();
                exp_q.push_back({1'(i == len - 1), b});
            end else begin
                need++;
            end
        end
    endtask

    task automatic start_frame(input int len, output int s);
        bit acc;
        acc = !frame_open && (len != 0);
        s = cyc;
        start = 1'b1;
        frame_len = LEN_W'(len);
        step();
        start = 1'b0;
        frame_len = LEN_W'($urandom);
        if (acc) begin
            frame_open = 1'b1;
            accept_frame(len);
        end
    endtask

    task automatic do_reset();
        srst = 1'b1;
        step();
        exp_q.delete();
        src = q;
        need = 0;
        frame_open = 1'b0;
        done_pending = 1'b0;
        rd_cnt = 0;
        hs_cnt = 0;
        srst = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (frame_open && n < 600) begin
            step();
            n++;
        end
        n_vec++;
        if (frame_open) begin
            n_err++;
            $display("FAIL idle_timeout cyc=%0d got=busy exp=idle", cyc);
        end
        step();
    endtask

    task automatic wait_hs(input int target);
        int n = 0;
        while (hs_cnt < target && n < 400) begin
            step();
            n++;
        end
        n_vec++;
        if (hs_cnt < target) begin
            n_err++;
            $display("FAIL hs_timeout cyc=%0d got=%0d exp=%0d", cyc, hs_cnt, target);
        end
    endtask

    task automatic test_reset();
        srst = 1'b1;
        step();
        push_byte(8'hA5);
        step();
        @(negedge rclk);
        n_vec++;
        if ({busy, done, fifo_r_en, m_valid, m_last} !== 5'b0 || m_data !== '0) begin
            n_err++;
            $display("FAIL reset_vals got=%0b%0b%0b%0b%0b/%02h exp=00000/00", busy, done, fifo_r_en, m_valid, m_last, m_data);
        end
`ifdef RD_STATS_EN
        n_vec++;
        if (frame_cnt !== 16'd0) begin
            n_err++;
            $display("FAIL reset_cnt got=%0d exp=0", frame_cnt);
        end
`endif
        step();
        do_reset();
        mon_en = 1'b1;
        step();
    endtask

    task automatic test_streaming();
        int s;
        ready_mode = 0;
        step();
        for (int i = 1; i <= 5; i++) push_byte(8'(i));
        rd_cyc.delete();
        hs_cyc.delete();
        start_frame(5, s);
        wait_idle();
        n_vec++;
        if (rd_cyc.size() < 1 || rd_cyc[0] != s + 1) begin
            n_err++;
            $display("FAIL first_read got=%0d exp=%0d", (rd_cyc.size() > 0) ? rd_cyc[0] - s : -1, 1);
        end
        n_vec++;
        if (hs_cyc.size() != 5) begin
            n_err++;
            $display("FAIL stream_count got=%0d exp=5", hs_cyc.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                n_vec++;
                if (hs_cyc[i] != s + 3 + i) begin
                    n_err++;
                    $display("FAIL stream_cycle idx=%0d got=%0d exp=%0d", i, hs_cyc[i] - s, 3 + i);
                end
            end
            n_vec++;
            if (last_done_cyc != hs_cyc[4] + 12) begin
                n_err++;
                $display("FAIL done_delay got=%0d exp=12", last_done_cyc - hs_cyc[4]);
            end
        end
    endtask

    task automatic test_backpressure();
        int s;
        int r0;
        ready_mode = 2;
        for (int i = 0; i < 8; i++) push_byte(8'($urandom));
        r0 = rd_cnt;
        start_frame(8, s);
        wait_idle();
        n_vec++;
        if (rd_cnt - r0 != 8) begin
            n_err++;
            $display("FAIL bp_reads got=%0d exp=8", rd_cnt - r0);
        end
        n_vec++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL bp_left got=%0d exp=0", exp_q.size());
        end
    endtask

    task automatic test_empty_stall();
        int s;
        int h0;
        ready_mode = 1;
        while (q.size() != 0) void'(q.pop_front());
        src.delete();
        fifo_empty = 1'b1;
        step();
        for (int i = 0; i < 3; i++) push_byte(8'h30 + 8'(i));
        h0 = hs_cnt;
        start_frame(6, s);
        repeat (20) step();
        n_vec++;
        if (hs_cnt - h0 != 3) begin
            n_err++;
            $display("FAIL stall_partial got=%0d exp=3", hs_cnt - h0);
        end
        for (int i = 3; i < 6; i++) push_byte(8'h30 + 8'(i));
        wait_idle();
        n_vec++;
        if (hs_cnt - h0 != 6) begin
            n_err++;
            $display("FAIL stall_total got=%0d exp=6", hs_cnt - h0);
        end
    endtask

    task automatic test_boundaries();
        int s;
        int h0;
        ready_mode = 0;
        start_frame(0, s);
        repeat (3) begin
            @(negedge rclk);
            n_vec++;
            if (busy !== 1'b0 || done !== 1'b0) begin
                n_err++;
                $display("FAIL len0 got=%0b%0b exp=00", busy, done);
            end
            step();
        end
        push_byte(8'hC1);
        h0 = hs_cnt;
        start_frame(1, s);
        wait_idle();
        n_vec++;
        if (hs_cnt - h0 != 1) begin
            n_err++;
            $display("FAIL len1 got=%0d exp=1", hs_cnt - h0);
        end
        for (int i = 0; i < 4; i++) push_byte(8'hD0 + 8'(i));
        h0 = hs_cnt;
        start_frame(2, s);
        wait_hs(h0 + 2);
        repeat (3) step();
        start_frame(2, s);
        wait_idle();
        repeat (4) step();
        n_vec++;
        if (q.size() != 2) begin
            n_err++;
            $display("FAIL gap_start got=%0d exp=2", q.size());
        end
    endtask

    task automatic test_reset_midframe();
        int s;
        int h0;
        ready_mode = 0;
        for (int i = 0; i < 10; i++) push_byte(8'h50 + 8'(i));
        h0 = hs_cnt;
        start_frame(10, s);
        wait_hs(h0 + 4);
        do_reset();
        @(negedge rclk);
        n_vec++;
        if (m_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            n_err++;
            $display("FAIL mid_reset got=%0b%0b%0b exp=000", m_valid, busy, done);
        end
        step();
        for (int i = 0; i < 5; i++) push_byte(8'h70 + 8'(i));
        start_frame(5, s);
        wait_idle();
        n_vec++;
        if (exp_q.size() != 0 || need != 0) begin
            n_err++;
            $display("FAIL post_reset got=%0d exp=0", exp_q.size() + need);
        end
    endtask

    task automatic test_random();
        int s;
        int len;
        int k;
        for (int it = 0; it < 25; it++) begin
            ready_mode = int'($urandom_range(0, 1));
            len = int'($urandom_range(1, 16));
            k = int'($urandom_range(0, len));
            for (int i = 0; i < k; i++) push_byte(8'($urandom));
            start_frame(len, s);
            repeat ($urandom_range(0, 8)) step();
            for (int i = k; i < len; i++) push_byte(8'($urandom));
            wait_idle();
            n_vec++;
            if (exp_q.size() != 0 || need != 0) begin
                n_err++;
                $display("FAIL rand_frame it=%0d got=%0d exp=0", it, exp_q.size() + need);
            end
        end
    endtask

`ifdef RD_STATS_EN
    task automatic test_stats();
        int s;
        logic [15:0] before;
        ready_mode = 0;
        before = frame_cnt;
        for (int f = 0; f < 3; f++) begin
            push_byte(8'($urandom));
            push_byte(8'($urandom));
            start_frame(2, s);
            wait_idle();
        end
        n_vec++;
        if (frame_cnt !== before + 16'd3) begin
            n_err++;
            $display("FAIL stats_cnt got=%0d exp=%0d", frame_cnt, before + 16'd3);
        end
        force dut.frame_cnt = 16'hFFFF;
        step();
        release dut.frame_cnt;
        push_byte(8'($urandom));
        push_byte(8'($urandom));
        start_frame(2, s);
        wait_idle();
        n_vec++;
        if (frame_cnt !== 16'hFFFF) begin
            n_err++;
            $display("FAIL stats_sat got=%0h exp=ffff", frame_cnt);
        end
    endtask
`endif

    initial begin
        srst       = 1'b1;
        start      = 1'b0;
        frame_len  = '0;
        fifo_empty = 1'b1;
        fifo_data  = '0;
        m_ready    = 1'b1;
        step();
        test_reset();
        test_streaming();
        test_backpressure();
        test_empty_stall();
        test_boundaries();
        test_reset_midframe();
        test_random();
`ifdef RD_STATS_EN
        test_stats();
`endif
        repeat (4) step();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
